// File: rtl/geofence_feeder.sv
// geofence_feeder: sequences target points and a double-buffered fence polygon into a geofence core.
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   fence_we/idx/x/y     shadow vertex bank write (idx 6-7 ignored)
//   tgt_push/x/y         target point push into a 4-deep tagged FIFO
//   tgt_ready            FIFO not full
//   gf_x, gf_y           per-frame stream: head point, then active vertices 0-5
//   gf_valid/is_inside   geofence core result
//   res_valid/inside/tag registered result, tagged with its target's sequence number
//   err                  sticky WAIT timeout
module geofence_feeder (
  input  logic       clk,
  input  logic       reset,
  input  logic       fence_we,
  input  logic [2:0] fence_idx,
  input  logic [9:0] fence_x,
  input  logic [9:0] fence_y,
  input  logic       tgt_push,
  input  logic [9:0] tgt_x,
  input  logic [9:0] tgt_y,
  output logic       tgt_ready,
  output logic [9:0] gf_x,
  output logic [9:0] gf_y,
  input  logic       gf_valid,
  input  logic       gf_is_inside,
  output logic       res_valid,
  output logic       res_inside,
  output logic [3:0] res_tag,
  output logic       err
);
  typedef enum logic {S_FRAME, S_WAIT} state_t;
  state_t     state_q;
  logic [2:0] beat_q;
  logic [7:0] wcnt_q;
  logic [9:0] sh_x_q [6];
  logic [9:0] sh_y_q [6];
  logic [9:0] ac_x_q [6];
  logic [9:0] ac_y_q [6];
  logic [9:0] fx_q [4];
  logic [9:0] fy_q [4];
  logic [3:0] ft_q [4];
  logic [1:0] rd_q, wr_q;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] tag_q, ftag_q;
  logic       real_q;
  logic       empty, full, push, pop, beat0;
  logic [2:0] vidx;
  assign empty     = cnt_q == 3'd0;
  assign full      = cnt_q == 3'd4;
  assign beat0     = state_q == S_FRAME && beat_q == 3'd0;
  assign push      = tgt_push && !full;
  assign pop       = beat0 && !empty;
  assign cnt_d     = cnt_q + {2'b0, push} - {2'b0, pop};
  assign tgt_ready = !full;
  assign vidx      = beat_q - 3'd1;
  // Stream is a pure function of registered state: head (or 0,0 when empty) at beat 0,
  // active vertices on beats 1-6, zeros while waiting.
  assign gf_x = state_q != S_FRAME ? 10'd0 : beat_q == 3'd0 ? (empty ? 10'd0 : fx_q[rd_q]) : ac_x_q[vidx];
  assign gf_y = state_q != S_FRAME ? 10'd0 : beat_q == 3'd0 ? (empty ? 10'd0 : fy_q[rd_q]) : ac_y_q[vidx];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FRAME;
      beat_q     <= 3'd0;
      wcnt_q     <= 8'd0;
      rd_q       <= 2'd0;
      wr_q       <= 2'd0;
      cnt_q      <= 3'd0;
      tag_q      <= 4'd0;
      ftag_q     <= 4'd0;
      real_q     <= 1'b0;
      res_valid  <= 1'b0;
      res_inside <= 1'b0;
      res_tag    <= 4'd0;
      err        <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        sh_x_q[i] <= 10'd0;
        sh_y_q[i] <= 10'd0;
        ac_x_q[i] <= 10'd0;
        ac_y_q[i] <= 10'd0;
      end
      for (int i = 0; i < 4; i++) begin
        fx_q[i] <= 10'd0;
        fy_q[i] <= 10'd0;
        ft_q[i] <= 4'd0;
      end
    end else begin
      res_valid <= 1'b0;
      cnt_q     <= cnt_d;
      if (fence_we && fence_idx < 3'd6) begin
        sh_x_q[fence_idx] <= fence_x;
        sh_y_q[fence_idx] <= fence_y;
      end
      if (push) begin
        fx_q[wr_q] <= tgt_x;
        fy_q[wr_q] <= tgt_y;
        ft_q[wr_q] <= tag_q;
        wr_q       <= wr_q + 2'd1;
        tag_q      <= tag_q + 4'd1;
      end
      if (pop)
        rd_q <= rd_q + 2'd1;
      if (state_q == S_FRAME) begin
        // Beat 0 fixes the frame: real/dummy, its tag, and the vertex snapshot.
        // The copy reads the pre-edge shadow, so a same-cycle write lands in the next frame.
        if (beat_q == 3'd0) begin
          real_q <= !empty;
          ftag_q <= ft_q[rd_q];
          for (int i = 0; i < 6; i++) begin
            ac_x_q[i] <= sh_x_q[i];
            ac_y_q[i] <= sh_y_q[i];
          end
        end
        beat_q <= beat_q == 3'd6 ? 3'd0 : beat_q + 3'd1;
        if (beat_q == 3'd6) begin
          state_q <= S_WAIT;
          wcnt_q  <= 8'd0;
        end
      end else if (gf_valid) begin
        state_q   <= S_FRAME;
        res_valid <= real_q;
        if (real_q) begin
          res_inside <= gf_is_inside;
          res_tag    <= ftag_q;
        end
      end else if (wcnt_q == 8'd254) begin
        // 255th consecutive WAIT cycle without a result: drop the frame.
        err     <= 1'b1;
        state_q <= S_FRAME;
      end else begin
        wcnt_q <= wcnt_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_geofence_feeder.sv
// tb_geofence_feeder: plays the geofence core and checks the feeder against a queue-based model.
module tb_geofence_feeder;
  logic       clk, reset, fence_we, tgt_push, tgt_ready, gf_valid, gf_is_inside;
  logic       res_valid, res_inside, err;
  logic [2:0] fence_idx;
  logic [9:0] fence_x, fence_y, tgt_x, tgt_y, gf_x, gf_y;
  logic [3:0] res_tag;
  geofence_feeder dut (
    .clk(clk), .reset(reset), .fence_we(fence_we), .fence_idx(fence_idx),
    .fence_x(fence_x), .fence_y(fence_y), .tgt_push(tgt_push), .tgt_x(tgt_x),
    .tgt_y(tgt_y), .tgt_ready(tgt_ready), .gf_x(gf_x), .gf_y(gf_y),
    .gf_valid(gf_valid), .gf_is_inside(gf_is_inside), .res_valid(res_valid),
    .res_inside(res_inside), .res_tag(res_tag), .err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {int x; int y; int tag;} tgt_t;
  tgt_t q[$];
  int   tag, nvec, nfail, rnd_pct, last_v2x;
  bit   rnd_we, stray, err_m;
  int   sx[6], sy[6], ax[6], ay[6];
  bit   sp_en[7], sw_en[7];
  int   sp_x[7], sp_y[7], sw_i[7], sw_x[7], sw_y[7];
  int   hex_x[6] = '{100, 300, 400, 300, 100, 0};
  int   hex_y[6] = '{100, 100, 300, 500, 500, 300};
  int   b16_in[4] = '{1, 0, 0, 1};
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask
  // Ray-casting point-in-polygon using cross-multiplication instead of division.
  function automatic bit pip(input int px, input int py, input int vx[6], input int vy[6]);
    bit c = 0;
    for (int i = 0; i < 6; i++) begin
      int j = (i + 5) % 6;
      int d = vy[j] - vy[i];
      int l = (px - vx[i]) * d;
      int r = (py - vy[i]) * (vx[j] - vx[i]);
      if ((vy[i] > py) != (vy[j] > py))
        if (d > 0 ? l < r : l > r) c = !c;
    end
    return c;
  endfunction
  task automatic model_reset();
    q.delete();
    tag = 0;
    err_m = 0;
    for (int i = 0; i < 6; i++) begin
      sx[i] = 0; sy[i] = 0; ax[i] = 0; ay[i] = 0;
    end
  endtask
  task automatic cyc(input bit pop);
    bit acc;
    if (rnd_pct > 0 && !tgt_push) begin
      tgt_push = $urandom_range(99) < rnd_pct;
      tgt_x = 10'($urandom_range(1023));
      tgt_y = 10'($urandom_range(1023));
    end
    if (rnd_we && !fence_we && $urandom_range(9) == 0) begin
      fence_we = 1'b1;
      fence_idx = 3'($urandom_range(7));
      fence_x = 10'($urandom_range(1023));
      fence_y = 10'($urandom_range(1023));
    end
    chk("tgt_ready", tgt_ready, q.size() < 4);
    acc = tgt_push && q.size() < 4;
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back('{int'(tgt_x), int'(tgt_y), tag});
      tag = (tag + 1) % 16;
    end
    if (fence_we && fence_idx < 3'd6) begin
      sx[fence_idx] = int'(fence_x);
      sy[fence_idx] = int'(fence_y);
    end
    tgt_push = 1'b0;
    fence_we = 1'b0;
    gf_valid = 1'b0;
  endtask
  // mode 0: result after lat WAIT cycles; mode 1: timeout; mode 2: reset pulse mid-WAIT.
  task automatic frame(input int lat, input int mode);
    bit real_f;
    int ex, ey, etag, cx, cy;
    int cvx[6], cvy[6];
    real_f = q.size() > 0;
    ex   = real_f ? q[0].x : 0;
    ey   = real_f ? q[0].y : 0;
    etag = real_f ? q[0].tag : 0;
    ax = sx;
    ay = sy;
    cx = 0; cy = 0;
    for (int b = 0; b < 7; b++) begin
      if (sp_en[b]) begin
        tgt_push = 1'b1; tgt_x = 10'(sp_x[b]); tgt_y = 10'(sp_y[b]); sp_en[b] = 0;
      end
      if (sw_en[b]) begin
        fence_we = 1'b1; fence_idx = 3'(sw_i[b]); fence_x = 10'(sw_x[b]); fence_y = 10'(sw_y[b]); sw_en[b] = 0;
      end
      if (stray && b > 0 && $urandom_range(3) == 0) begin
        gf_valid = 1'b1; gf_is_inside = 1'($urandom_range(1));
      end
      if (b == 0) begin
        chk("gf_x_head", gf_x, ex);
        chk("gf_y_head", gf_y, ey);
        cx = int'(gf_x); cy = int'(gf_y);
      end else begin
        chk("gf_x_vtx", gf_x, ax[b-1]);
        chk("gf_y_vtx", gf_y, ay[b-1]);
        chk("res_valid_beat", res_valid, 0);
        cvx[b-1] = int'(gf_x); cvy[b-1] = int'(gf_y);
      end
      cyc(b == 0 && real_f);
    end
    last_v2x = cvx[2];
    if (mode == 1) begin
      for (int w = 0; w < 255; w++) begin
        chk("err_wait", err, err_m);
        chk("gf_x_wait", gf_x, 0);
        cyc(0);
      end
      err_m = 1;
      chk("err_timeout", err, 1);
      chk("res_valid_timeout", res_valid, 0);
      return;
    end
    if (mode == 2) begin
      cyc(0); cyc(0);
      reset = 1'b1; gf_valid = 1'b1; gf_is_inside = 1'b1;
      #1;
      chk("rst_gf_x", gf_x, 0);
      chk("rst_gf_y", gf_y, 0);
      chk("rst_ready", tgt_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_inside", res_inside, 0);
      chk("rst_res_tag", res_tag, 0);
      chk("rst_err", err, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_hold_valid", res_valid, 0);
      reset = 1'b0; gf_valid = 1'b0;
      model_reset();
      return;
    end
    for (int w = 0; w < lat; w++) begin
      gf_is_inside = 1'($urandom_range(1));
      chk("gf_x_wait", gf_x, 0);
      chk("gf_y_wait", gf_y, 0);
      chk("res_valid_wait", res_valid, 0);
      cyc(0);
    end
    gf_valid = 1'b1;
    gf_is_inside = pip(cx, cy, cvx, cvy);
    cyc(0);
    chk("res_valid", res_valid, real_f);
    if (real_f) begin
      chk("res_inside", res_inside, pip(ex, ey, ax, ay));
      chk("res_tag", res_tag, etag);
    end
    chk("err", err, err_m);
  endtask
  task automatic rst_pulse();
    reset = 1'b1;
    #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask
  task automatic load_fence();
    for (int i = 0; i < 6; i++) begin
      sw_en[i] = 1; sw_i[i] = i; sw_x[i] = hex_x[i]; sw_y[i] = hex_y[i];
    end
  endtask
  initial begin
    nvec = 0; nfail = 0; rnd_pct = 0; rnd_we = 0; stray = 0;
    reset = 1'b1; fence_we = 1'b0; fence_idx = 3'd0; fence_x = 10'd0; fence_y = 10'd0;
    tgt_push = 1'b0; tgt_x = 10'd0; tgt_y = 10'd0; gf_valid = 1'b0; gf_is_inside = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("init_gf_x", gf_x, 0);
    chk("init_gf_y", gf_y, 0);
    chk("init_ready", tgt_ready, 1);
    chk("init_res_valid", res_valid, 0);
    chk("init_res_inside", res_inside, 0);
    chk("init_res_tag", res_tag, 0);
    chk("init_err", err, 0);
    reset = 1'b0;
    // Single target against the hexagon fence.
    load_fence();
    sp_en[6] = 1; sp_x[6] = 200; sp_y[6] = 300;
    frame(2, 0);
    frame(0, 0);
    chk("r015_inside", res_inside, 1);
    chk("r015_tag", res_tag, 0);
    // Four back-to-back pushes fill the FIFO; a fifth at pop time is dropped.
    rst_pulse();
    load_fence();
    sp_en[1] = 1; sp_x[1] = 200; sp_y[1] = 300;
    sp_en[2] = 1; sp_x[2] = 600; sp_y[2] = 600;
    sp_en[3] = 1; sp_x[3] = 5;   sp_y[3] = 5;
    sp_en[4] = 1; sp_x[4] = 250; sp_y[4] = 400;
    frame(1, 0);
    chk("r016_full", tgt_ready, 0);
    sp_en[0] = 1; sp_x[0] = 7; sp_y[0] = 7;
    for (int k = 0; k < 4; k++) begin
      frame(k + 1, 0);
      chk("r016_inside", res_inside, b16_in[k]);
      chk("r016_tag", res_tag, k);
    end
    // Empty at beat 0: dummy frame; a same-cycle push waits for the next frame.
    sp_en[0] = 1; sp_x[0] = 250; sp_y[0] = 400;
    frame(3, 0);
    chk("r017_dummy", res_valid, 0);
    frame(0, 0);
    chk("r017_tag", res_tag, 4);
    // Vertex 2 rewritten mid-frame only shows up in the following frame.
    sw_en[3] = 1; sw_i[3] = 2; sw_x[3] = 420; sw_y[3] = 300;
    sw_en[4] = 1; sw_i[4] = 2; sw_x[4] = 440; sw_y[4] = 300;
    sw_en[5] = 1; sw_i[5] = 2; sw_x[5] = 450; sw_y[5] = 310;
    frame(2, 0);
    chk("r018_old", last_v2x, 400);
    sp_en[6] = 1; sp_x[6] = 200; sp_y[6] = 300;
    frame(2, 0);
    chk("r018_new", last_v2x, 450);
    frame(254, 0);
    chk("lat254_no_err", err, 0);
    // Randomized traffic, fence rewrites and stray result strobes.
    rnd_pct = 40; rnd_we = 1; stray = 1;
    repeat (30) frame($urandom_range(12), 0);
    rnd_pct = 0; rnd_we = 0; stray = 0;
    // Timeout, then reset in the middle of WAIT.
    frame(0, 1);
    chk("r019_err", err, 1);
    frame(1, 0);
    frame(3, 2);
    frame(1, 0);
    chk("r019_no_result", res_valid, 0);
    load_fence();
    sp_en[6] = 1; sp_x[6] = 250; sp_y[6] = 400;
    frame(0, 0);
    frame(2, 0);
    chk("post_rst_tag", res_tag, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/geofence_feeder.md
GEOFENCE_FEEDER -- requirements
Module: geofence_feeder

Interface
REQ-001 SHALL have the following ports.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; shared with the downstream geofence core.
- fence_we  in  1  write strobe for the shadow vertex bank.
- fence_idx  in  3  vertex index, 0-5; values 6-7 are ignored.
- fence_x, fence_y  in  10 each  vertex coordinates, unsigned.
- tgt_push  in  1  push a target point into the FIFO.
- tgt_x, tgt_y  in  10 each  target coordinates, unsigned.
- tgt_ready  out  1  FIFO not full.
- gf_x, gf_y  out  10 each  stream to the geofence core X/Y inputs.
- gf_valid  in  1  geofence result strobe.
- gf_is_inside  in  1  geofence result bit.
- res_valid  out  1  result strobe, one cycle.
- res_inside  out  1  result bit.
- res_tag  out  4  sequence tag of the target the result belongs to.
- err  out  1  sticky timeout flag.

Function
REQ-002 SHALL contain two 6-entry vertex banks, shadow and active, each 10+10 bits per entry.
- fence_we with fence_idx<6 writes the shadow bank at the clock edge.
REQ-003 SHALL contain a 4-entry target FIFO; each entry is {x, y, tag}.
- tag comes from a 4-bit counter that increments on each accepted push and wraps 15->0.
REQ-004 SHALL assert tgt_ready = !full; tgt_push while full SHALL be dropped, with no change to the tag counter.
REQ-005 SHALL use states FRAME (beat counter 0-6) and WAIT.
- Reset enters FRAME with beat 0.
- FRAME advances one beat per cycle; after beat 6 it goes to WAIT.
- WAIT goes to FRAME beat 0 on the cycle after a gf_valid=1 cycle.
REQ-006 SHALL drive gf_x/gf_y combinationally from registered state only; no path from any input port to gf_x/gf_y.
- Beat 0: the FIFO head, or (0,0) for a dummy frame.
- Beats 1-6: active vertex 0-5.
- WAIT: hold (0,0).
REQ-007 SHALL decide at beat 0 whether the frame is real or dummy.
- Real when the FIFO is non-empty at the start of the cycle; the head is popped at the end of beat 0 and its tag is latched as the frame tag.
- Dummy when the FIFO is empty at the start of beat 0; a push in that same cycle is not used by this frame.
REQ-008 SHALL copy shadow to active at the end of beat 0, so beats 1-6 of each frame see one consistent snapshot.
- A shadow write in the beat 0 cycle is not included in that copy; it applies to the next frame.
REQ-009 SHALL, on gf_valid=1 in WAIT of a real frame, register in the next cycle: res_valid=1, res_inside=gf_is_inside, res_tag=frame tag.
- A dummy frame's result SHALL be discarded with res_valid=0.
- gf_valid outside WAIT SHALL be ignored.
REQ-010 SHALL allow push and pop in the same cycle.
- Occupancy is unchanged.
- When the FIFO is full, the push is dropped per REQ-004.
REQ-011 SHALL count WAIT cycles in an 8-bit counter.
- If 255 cycles elapse without gf_valid: set err, discard the frame, return to FRAME beat 0.
- err clears only on reset.
REQ-012 SHALL give a latency from popping the FIFO head to res_valid of 7 + geofence processing time + 1 cycles.
- Results are delivered in FIFO order.

Reset
REQ-013 SHALL, on reset, force:
- state FRAME beat 0;
- FIFO empty, tag counter 0;
- both vertex banks all zero;
- gf_x=gf_y=0, tgt_ready=1;
- res_valid=0, res_inside=0, res_tag=0, err=0.
REQ-014 SHALL abort any frame or pending result immediately when reset asserts mid-operation; no res_valid follows.

Verification
REQ-015 Shadow vertices (100,100),(300,100),(400,300),(300,500),(100,500),(0,300); one push (200,300) before the first real frame -> res_valid=1, res_inside=1, res_tag=0.
REQ-016 Same fence, four back-to-back pushes (200,300),(600,600),(5,5),(250,400) -> tgt_ready=0 after the 4th push; results 1,0,0,1 with tags 0,1,2,3 in order.
REQ-017 FIFO empty at beat 0 -> gf_x=gf_y=0 at beat 0 and no res_valid for that frame; a push in the same cycle is served by the next frame.
REQ-018 Shadow vertex 2 rewritten during beats 3-5 -> the current frame still streams the old vertex 2; the next frame streams the new one.
REQ-019 Hold gf_valid=0 in WAIT -> err=1 after 255 cycles and the state machine returns to beat 0; a reset pulse mid-WAIT -> all outputs at reset values and no res_valid.
